cva6_rvfi_trace_buffer: RTL

- Consumer end of the per-cycle RVFI retirement interface driven by the core's RVFI packer.
- Accepts up to NrCommitPorts retirement records per cycle, stamps each with a 64-bit retirement order number, buffers them in a FIFO, and drains one record per cycle over a valid/ready handshake to a trace writer or checker.
- Reports drops on overflow and keeps a saturating drop counter.

---
 rtl/cva6_rvfi_trace_buffer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cva6_rvfi_trace_buffer.sv
// RVFI retirement trace buffer: stamps each retired record with a 64-bit order
// number, queues it, and drains one record per cycle over valid/ready.

package cva6_rvfi_trace_buffer_pkg;
  typedef struct packed {
    int unsigned NrCommitPorts;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd2};

  typedef struct packed {
    logic        valid;
    logic        trap;
    logic [63:0] pc_rdata;
    logic [31:0] insn;
  } rvfi_instr_default_t;
endpackage

module cva6_rvfi_trace_buffer #(
  parameter cva6_rvfi_trace_buffer_pkg::cva6_cfg_t CVA6Cfg = cva6_rvfi_trace_buffer_pkg::cva6_cfg_empty,
  parameter type rvfi_instr_t = cva6_rvfi_trace_buffer_pkg::rvfi_instr_default_t,
  parameter int unsigned Depth = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  rvfi_instr_t [CVA6Cfg.NrCommitPorts-1:0]  rvfi_instr_i,
  input  logic                                     clear_i,
  output logic                                     trace_valid_o,
  input  logic                                     trace_ready_i,
  output rvfi_instr_t                              trace_instr_o,
  output logic [63:0]                              trace_order_o,
  output logic [$clog2(Depth):0]                   level_o,
  output logic                                     overflow_o,
  output logic [31:0]                              drop_count_o
);
  localparam int unsigned NrPorts = CVA6Cfg.NrCommitPorts;
  localparam int unsigned AW      = $clog2(Depth);
  localparam int unsigned PW      = AW + 1;
  localparam logic [PW-1:0] DepthW = PW'(Depth);

  typedef struct packed {
    rvfi_instr_t instr;
    logic [63:0] order;
  } entry_t;

  entry_t mem [Depth];

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [63:0]   order_reg;
  logic          overflow_reg;
  logic [31:0]   drop_count_reg;

  logic [PW-1:0] level, free, n_valid, n_write, n_drop;
  logic          pop;
  logic [NrPorts-1:0][PW-1:0] rank;
  logic [NrPorts-1:0]         port_write;
  logic [AW-1:0]              wr_idx [NrPorts];
  entry_t                     wr_entry [NrPorts];
  logic [32:0]                drop_sum;
  logic [31:0]                drop_count_next;

  assign level         = wr_ptr_reg - rd_ptr_reg;
  assign trace_valid_o = (wr_ptr_reg != rd_ptr_reg);
  assign pop           = trace_valid_o & trace_ready_i;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept one record.
  assign free          = DepthW - level + {{(PW-1){1'b0}}, pop};

  // Rank of each valid port among the valid ports below it; invalid ports take no order number.
  always_comb begin
    logic [PW-1:0] acc;
    acc = '0;
    rank = '0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      rank[i] = acc;
      if (rvfi_instr_i[i].valid) begin
        acc = acc + PW'(1);
      end
    end
    n_valid = acc;
  end

  assign n_write = (n_valid > free) ? free : n_valid;
  assign n_drop  = clear_i ? '0 : (n_valid - n_write);

  for (genvar gi = 0; gi < NrPorts; gi++) begin : g_port
    assign port_write[gi] = rvfi_instr_i[gi].valid && !clear_i && (rank[gi] < free);
    assign wr_idx[gi]     = wr_ptr_reg[AW-1:0] + rank[gi][AW-1:0];
    assign wr_entry[gi]   = {rvfi_instr_i[gi], order_reg + 64'(rank[gi])};
  end

  assign drop_sum        = {1'b0, drop_count_reg} + 33'(n_drop);
  assign drop_count_next = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NrPorts; p++) begin
        if (port_write[p]) begin
          mem[wr_idx[p]] <= wr_entry[p];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      order_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      // Order numbers advance for every valid record, including dropped or flushed ones.
      order_reg      <= order_reg + 64'(n_valid);
      drop_count_reg <= drop_count_next;
      if (clear_i) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        overflow_reg <= 1'b0;
      end else begin
        wr_ptr_reg <= wr_ptr_reg + n_write;
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
        if (n_drop != '0) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

  assign trace_instr_o = mem[rd_ptr_reg[AW-1:0]].instr;
  assign trace_order_o = mem[rd_ptr_reg[AW-1:0]].order;
  assign level_o       = level;
  assign overflow_o    = overflow_reg;
  assign drop_count_o  = drop_count_reg;

endmodule
